// File: rtl/reaction_timer_ctrl.sv
// reaction_timer_ctrl: reaction-timer control stage for the 1 kHz stopwatch chain.
// One clock is one millisecond. After a start press the block waits for a
// pseudo-random delay, lights the stimulus LED, and then counts milliseconds
// until a stop press. The result is held on ms_count for the BCD converter.
// Optional feature macro: REACTION_BEST_EN adds the best_ms output, which keeps
// the fastest valid reaction seen since reset.
module reaction_timer_ctrl #(
   parameter int unsigned MAX_COUNT  = 999999,
   parameter int unsigned DELAY_MIN  = 1000,
   parameter int unsigned DELAY_BITS = 12
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic        stop,
   output logic [19:0] ms_count,
   output logic        stim_led,
   output logic        false_start
`ifdef REACTION_BEST_EN
   ,
   output logic [19:0] best_ms
`endif
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_WAIT   = 3'd1;
   localparam logic [2:0] S_TIMING = 3'd2;
   localparam logic [2:0] S_DONE   = 3'd3;
   localparam logic [2:0] S_FOUL   = 3'd4;

   localparam logic [19:0] MAX_C   = 20'(MAX_COUNT);
   localparam logic [15:0] DMIN16  = 16'(DELAY_MIN);
   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   // Button synchronizers and edge detect (released level is 1)
   logic start_s1_q, start_s2_q, start_prev_q;
   logic stop_s1_q, stop_s2_q, stop_prev_q;
   logic start_press, stop_press;

   // Pseudo-random source
   logic [15:0] lfsr_q;
   logic        lfsr_fb;

   // Control state and outputs
   logic [2:0]  state_q, state_d;
   logic [15:0] delay_q, delay_d;
   logic [19:0] ms_q, ms_d;
   logic        stim_q, stim_d;
   logic        foul_q, foul_d;
   logic [15:0] delay_load;
`ifdef REACTION_BEST_EN
   logic [19:0] best_q, best_d;
`endif

   // A press is the first cycle the synchronized level is seen low
   assign start_press = start_prev_q & ~start_s2_q;
   assign stop_press  = stop_prev_q  & ~stop_s2_q;

   // Taps x^16+x^14+x^13+x^11+1; a non-zero seed keeps it out of the all-zero lock-up
   assign lfsr_fb    = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
   assign delay_load = DMIN16 + 16'(lfsr_q[DELAY_BITS-1:0]);

   // Two-flop synchronizers plus previous-value flops for both buttons
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         start_s1_q   <= 1'b1;
         start_s2_q   <= 1'b1;
         start_prev_q <= 1'b1;
         stop_s1_q    <= 1'b1;
         stop_s2_q    <= 1'b1;
         stop_prev_q  <= 1'b1;
      end else begin
         start_s1_q   <= start;
         start_s2_q   <= start_s1_q;
         start_prev_q <= start_s2_q;
         stop_s1_q    <= stop;
         stop_s2_q    <= stop_s1_q;
         stop_prev_q  <= stop_s2_q;
      end
   end

   // Free-running LFSR, stepped every clock regardless of state
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         lfsr_q <= LFSR_SEED;
      end else begin
         lfsr_q <= {lfsr_q[14:0], lfsr_fb};
      end
   end

   // Next-state and output logic; stop has priority in WAIT/TIMING, start elsewhere
   always_comb begin
      state_d = state_q;
      delay_d = delay_q;
      ms_d    = ms_q;
      stim_d  = stim_q;
      foul_d  = foul_q;
`ifdef REACTION_BEST_EN
      best_d  = best_q;
`endif
      case (state_q)
         S_WAIT: begin
            if (stop_press) begin
               state_d = S_FOUL;
               foul_d  = 1'b1;
               ms_d    = 20'd0;
            end else if (delay_q == 16'd0) begin
               state_d = S_TIMING;
               stim_d  = 1'b1;
            end else begin
               delay_d = delay_q - 16'd1;
            end
         end
         S_TIMING: begin
            if (stop_press) begin
               state_d = S_DONE;
               stim_d  = 1'b0;
`ifdef REACTION_BEST_EN
               if (ms_q < best_q) begin
                  best_d = ms_q;
               end
`endif
            end else if (ms_q != MAX_C) begin
               ms_d = ms_q + 20'd1;
            end
         end
         default: begin
            // IDLE, DONE and FOUL all wait for a start press
            if (start_press) begin
               state_d = S_WAIT;
               delay_d = delay_load;
               ms_d    = 20'd0;
               foul_d  = 1'b0;
               stim_d  = 1'b0;
            end
         end
      endcase
   end

   // Control and output registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         delay_q <= 16'd0;
         ms_q    <= 20'd0;
         stim_q  <= 1'b0;
         foul_q  <= 1'b0;
`ifdef REACTION_BEST_EN
         best_q  <= MAX_C;
`endif
      end else begin
         state_q <= state_d;
         delay_q <= delay_d;
         ms_q    <= ms_d;
         stim_q  <= stim_d;
         foul_q  <= foul_d;
`ifdef REACTION_BEST_EN
         best_q  <= best_d;
`endif
      end
   end

   assign ms_count    = ms_q;
   assign stim_led    = stim_q;
   assign false_start = foul_q;
`ifdef REACTION_BEST_EN
   assign best_ms     = best_q;
`endif

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Self-checking bench for reaction_timer_ctrl, built with shortened delay and
// saturation parameters so every scenario fits in a short run.
module tb_reaction_timer_ctrl;

   localparam int unsigned MAXC  = 500;
   localparam int unsigned DMIN  = 20;
   localparam int unsigned DBITS = 8;

   logic        clock;
   logic        reset;
   logic        start;
   logic        stop;
   logic [19:0] ms_count;
   logic        stim_led;
   logic        false_start;
`ifdef REACTION_BEST_EN
   logic [19:0] best_ms;
`endif

   int total = 0;
   int bad   = 0;

   reaction_timer_ctrl #(
      .MAX_COUNT (MAXC),
      .DELAY_MIN (DMIN),
      .DELAY_BITS(DBITS)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .stop       (stop),
      .ms_count   (ms_count),
      .stim_led   (stim_led),
      .false_start(false_start)
`ifdef REACTION_BEST_EN
      ,
      .best_ms    (best_ms)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference LFSR built from the polynomial, seed and reset behaviour
   logic [15:0] lfsr_m;
   always @(posedge clock or negedge reset) begin
      if (!reset) lfsr_m <= 16'hACE1;
      else        lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_outs(input string name, input int ms, input int stim, input int fs);
      chk({name, ".ms"},   int'(ms_count),    ms);
      chk({name, ".stim"}, int'(stim_led),    stim);
      chk({name, ".fs"},   int'(false_start), fs);
   endtask

   // Pulse the buttons for one cycle from a falling edge; returns after the
   // acting edge (two rising edges after the first sampling edge).
   task automatic do_press(input bit s, input bit p, output int dly);
      start = s ? 1'b0 : 1'b1;
      stop  = p ? 1'b0 : 1'b1;
      @(negedge clock);
      start = 1'b1;
      stop  = 1'b1;
      @(negedge clock);
      dly = int'(DMIN) + int'(lfsr_m[DBITS-1:0]);
      @(negedge clock);
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Counts cycles from the current falling edge until stim_led rises (bounded)
   task automatic wait_rise(input string name, input int dly);
      int r;
      r = 0;
      while (r < 2000) begin
         @(negedge clock);
         r++;
         if (stim_led) break;
      end
      if (!stim_led) begin
         total++;
         bad++;
         $display("FAIL %s: stim_led never rose, expected after %0d cycles", name, dly + 1);
      end else begin
         chk(name, r, dly + 1);
      end
   endtask

   typedef struct {
      int  k;         // TIMING entry edge to acting stop edge
      bit  both;      // start pressed together with stop
      int  exp_ms;
      int  exp_best;
   } vec_t;

   vec_t vecs [4];

   initial begin
      int d, first_d, tmp;
      bit varied;

      vecs[0] = '{k: 401, both: 1'b0, exp_ms: 400, exp_best: 400};
      vecs[1] = '{k: 251, both: 1'b0, exp_ms: 250, exp_best: 250};
      vecs[2] = '{k: 301, both: 1'b1, exp_ms: 300, exp_best: 250};
      vecs[3] = '{k: 3,   both: 1'b0, exp_ms: 2,   exp_best: 2};

      reset = 1'b0;
      start = 1'b1;
      stop  = 1'b1;
      wait_cycles(3);
      chk_outs("reset", 0, 0, 0);
`ifdef REACTION_BEST_EN
      chk("reset.best", int'(best_ms), int'(MAXC));
`endif
      reset = 1'b1;
      wait_cycles(2);

      // Reset asserted in TIMING at ms_count=300
      do_press(1'b1, 1'b0, d);
      chk_outs("rst_run.wait", 0, 0, 0);
      wait_rise("rst_run.rise", d);
      wait_cycles(300);
      chk_outs("rst_run.timing", 300, 1, 0);
      #2 reset = 1'b0;
      #1;
      chk_outs("rst_mid", 0, 0, 0);
`ifdef REACTION_BEST_EN
      chk("rst_mid.best", int'(best_ms), int'(MAXC));
`endif
      @(negedge clock);
      reset = 1'b1;
      wait_cycles(2);
      do_press(1'b0, 1'b1, tmp);
      wait_cycles(3);
      chk_outs("rst_stop_ignored", 0, 0, 0);

      // Table of measured runs
      for (int i = 0; i < 4; i++) begin
         do_press(1'b1, 1'b0, d);
         chk_outs($sformatf("vec%0d.start", i), 0, 0, 0);
         wait_rise($sformatf("vec%0d.rise", i), d);
         wait_cycles(vecs[i].k - 3);
         do_press(vecs[i].both, 1'b1, tmp);
         chk_outs($sformatf("vec%0d.stop", i), vecs[i].exp_ms, 0, 0);
         wait_cycles(5);
         chk($sformatf("vec%0d.hold", i), int'(ms_count), vecs[i].exp_ms);
`ifdef REACTION_BEST_EN
         chk($sformatf("vec%0d.best", i), int'(best_ms), vecs[i].exp_best);
`endif
      end

      // Random wait range over 20 starts at varied offsets
      first_d = 0;
      varied  = 1'b0;
      for (int i = 0; i < 20; i++) begin
         wait_cycles((i * 7) % 13);
         do_press(1'b1, 1'b0, d);
         if (i == 0) first_d = d;
         else if (d != first_d) varied = 1'b1;
         chk($sformatf("rnd%0d.range", i), int'(d >= int'(DMIN) && d <= int'(DMIN) + (1 << DBITS) - 1), 1);
         chk($sformatf("rnd%0d.clr", i), int'(ms_count), 0);
         wait_rise($sformatf("rnd%0d.rise", i), d);
         do_press(1'b0, 1'b1, tmp);
         chk($sformatf("rnd%0d.ms", i), int'(ms_count), 2);
      end
      chk("rnd.varied", int'(varied), 1);

      // Nominal run with stop held low well past the acting edge
      do_press(1'b1, 1'b0, d);
      wait_rise("held.rise", d);
      wait_cycles(247);
      stop = 1'b0;
      wait_cycles(30);
      stop = 1'b1;
      chk_outs("held.done", 249, 0, 0);
      wait_cycles(5);
      chk("held.after", int'(ms_count), 249);

      // Start and stop together in DONE: start wins
      do_press(1'b1, 1'b1, d);
      chk_outs("both_done", 0, 0, 0);
      // False start 10 cycles into WAIT
      wait_cycles(7);
      do_press(1'b0, 1'b1, tmp);
      chk_outs("foul", 0, 0, 1);
      wait_cycles(300);
      chk_outs("foul.stay", 0, 0, 1);
      do_press(1'b0, 1'b1, tmp);
      chk("foul.stop_ignored", int'(false_start), 1);
`ifdef REACTION_BEST_EN
      chk("foul.best", int'(best_ms), 2);
`endif
      do_press(1'b1, 1'b0, d);
      chk_outs("foul.restart", 0, 0, 0);
      wait_rise("foul.rise", d);

      // Saturation, then stop while saturated
      wait_cycles(600);
      chk_outs("sat", int'(MAXC), 1, 0);
      do_press(1'b0, 1'b1, tmp);
      chk_outs("sat.stop", int'(MAXC), 0, 0);
`ifdef REACTION_BEST_EN
      chk("sat.best", int'(best_ms), 2);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/reaction_timer_ctrl.md
# reaction_timer_ctrl

Reaction-timer control stage driving the millisecond display chain of the lab-2 stopwatch design. It runs on the 1 kHz clock from the clock divider, so one clock equals 1 ms. On a start press it waits a pseudo-random delay, lights a stimulus LED, then counts milliseconds until the stop press. It outputs the 20-bit binary `ms_count` consumed directly by the hex-to-BCD converter, replacing the free-running stopwatch counter.

## Interface
- `MAX_COUNT`, 999999: saturation value of `ms_count`, the six-digit display limit.
- `DELAY_MIN`, 1000: minimum random wait, in ms.
- `DELAY_BITS`, 12: number of LFSR bits added to `DELAY_MIN`, giving a wait range of 1000..5095 ms.
- `clock`  in  1  1 kHz clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (KEY[0]).
- `start`  in  1  active-low pushbutton (KEY[2]); asynchronous to `clock`.
- `stop`  in  1  active-low pushbutton (KEY[1]); asynchronous to `clock`.
- `ms_count`  out  20  reaction time in ms, binary.
- `stim_led`  out  1  stimulus indicator; high only in TIMING.
- `false_start`  out  1  high only in FOUL.

## Operation
- **Button conditioning:** each button passes through a 2-flop synchronizer plus a previous-value flop. A press is a single-cycle pulse on a 1→0 transition of the synchronized level. A held button produces exactly one press.
- **LFSR:** 16-bit Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1.
  - Seeded to 0xACE1 at reset.
  - Advances on every clock, independent of state.
  - Never holds 0.
- **States:** IDLE, WAIT, TIMING, DONE, FOUL.
- **IDLE, DONE, FOUL:**
  - A start press loads `delay_cnt` = `DELAY_MIN` + LFSR[`DELAY_BITS`-1:0], clears `ms_count` to 0, clears `false_start`, and enters WAIT.
  - A stop press is ignored.
- **WAIT:**
  - Each edge: if `delay_cnt`==0, enter TIMING and set `stim_led`=1; otherwise decrement `delay_cnt`.
  - A stop press enters FOUL with `false_start`=1 and `ms_count`=0.
  - A start press is ignored.
- **TIMING:**
  - Each edge, `ms_count` increments, saturating at `MAX_COUNT` (holds; no wrap).
  - A stop press enters DONE, clears `stim_led`, and freezes `ms_count`. The count does not increment on that edge.
  - A start press is ignored.
- **DONE:** `ms_count` holds the result until the next start press.
- **Simultaneous start and stop press:**
  - In WAIT or TIMING, stop wins.
  - In IDLE, DONE or FOUL, start wins.
- **Width rules:**
  - `delay_cnt` is 16 bits wide.
  - The `ms_count` comparison against `MAX_COUNT` is a 20-bit unsigned compare.

## Timing
- **Reset values:**
  - `ms_count`=0, `stim_led`=0, `false_start`=0, state IDLE, LFSR=0xACE1.
  - Synchronizer and previous-value flops reset to 1 (button released).
- **Reset mid-operation:** asynchronous assertion immediately returns all outputs to their reset values, from any state.
- **Press latency:** a button low at rising edge N is acted on at edge N+2, meaning the state and outputs change at N+2.
- **WAIT duration:** with delay D loaded, WAIT occupies D+1 cycles. `stim_led` rises at edge E+D+1, where E is the edge that entered WAIT.
- **Measured value:** TIMING entered at edge T and a stop acted on at edge T+k gives `ms_count`=k−1.
- **Outputs:** all outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- **Macro:** `REACTION_BEST_EN`.
- **Defined:**
  - Adds output `best_ms` (out, 20 bits), reset value `MAX_COUNT`.
  - On each transition TIMING→DONE, if the final `ms_count` is less than `best_ms`, `best_ms` takes the final `ms_count` on the same edge.
  - FOUL never updates `best_ms`.
- **Undefined:** the `best_ms` port and its register are absent; all other behaviour is identical.

## Test plan
- **Reset:** assert reset in TIMING with `ms_count`=300 → `ms_count`=0, `stim_led`=0, `false_start`=0 immediately; a stop press after release is ignored.
- **Random wait range:** 20 start presses at varied cycle offsets → each `stim_led` rise comes D+1 cycles after WAIT entry, with D in 1000..5095 and not all D equal.
- **Nominal measurement:** stop acted on 250 cycles after TIMING entry → `ms_count`=249 and held; a held stop button produces no further change.
- **False start:** stop press 10 cycles into WAIT → `false_start`=1, `stim_led` stays 0, `ms_count`=0; the next start press clears `false_start`.
- **Saturation:** no stop for 1,000,100 cycles in TIMING → `ms_count` stops at 999999; a stop press then gives DONE with 999999. A same-cycle start+stop in TIMING → DONE.
- **`REACTION_BEST_EN`:** runs of 400, 250 and 300 ms → `best_ms` reads 999999 after reset, then 400, then 250, and stays 250.
